// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, default gate width / expected code, row-to-bit mapping helper.
package tt_sweep_pkg;

    localparam int          DEF_N_IN     = 3;
    localparam logic [7:0]  DEF_EXPECTED = 8'hF4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Row 0 lands in the MSB so the packed table reads like the gate's hex code.
    function automatic int row_bit(input int tw, input int row);
        return tw - 1 - row;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Handshake/bus bundle between the sweeper and whatever starts it and hosts the gate.
// Latency: n/a (wires only).
// Backpressure: none; start is a level request, done a single-cycle pulse.
// Ports: master = sweeper side (drives stim and results), slave = requester/gate side.
interface truth_table_sweeper_if
    import tt_sweep_pkg::*;
#(
    parameter int N_IN = DEF_N_IN
);
    localparam int TW = 2 ** N_IN;

    logic            start;
    logic            busy;
    logic            done;
    logic [N_IN-1:0] stim;
    logic            dut_out;
    logic [TW-1:0]   table_code;
    logic            match;
    logic [TW-1:0]   mismatch_mask;

    modport master (
        input  start, dut_out,
        output busy, done, stim, table_code, match, mismatch_mask
    );

    modport slave (
        output start, dut_out,
        input  busy, done, stim, table_code, match, mismatch_mask
    );

endinterface

// File: rtl/truth_table_sweeper_timer.sv
// Settle counter: counts clocks a row has been applied, flags the last settle cycle.
// Latency: expire is combinational from the count; count advances one per enabled clock.
// Backpressure: none; clear has priority over enable.
// Ports: clk, reset (async active-high), clear, enable in; expire out.
module tt_settle_timer #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    logic [7:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 8'd0;
        end else if (clear) begin
            cnt <= 8'd0;
        end else if (enable) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expire = (cnt == 8'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 2^N_IN input rows of a gate, samples its output per row, packs and compares the code.
// Latency: done in cycle TW*(SETTLE_CYCLES+1)+1 after start is seen (41 for defaults).
// Backpressure: start ignored while busy (not queued); held start gives back-to-back sweeps.
// Ports: clk, reset (async active-high), bus (master modport: start/dut_out in; stim/busy/done/results out).
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int                 N_IN          = DEF_N_IN,
    parameter int                 SETTLE_CYCLES = 4,
    parameter logic [2**N_IN-1:0] EXPECTED      = DEF_EXPECTED
) (
    input logic                   clk,
    input logic                   reset,
    truth_table_sweeper_if.master bus
);
    localparam int              TW       = 2 ** N_IN;
    localparam logic [N_IN-1:0] ROW_LAST = '1;

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("truth_table_sweeper: SETTLE_CYCLES must be within 1..255");
    end

    state_t          state;
    state_t          state_nxt;
    logic [N_IN-1:0] row;
    logic [TW-1:0]   shadow;
    logic [TW-1:0]   shadow_nxt;
    logic [TW-1:0]   table_code;
    logic [TW-1:0]   mismatch_mask;
    logic            match;
    logic            expire;
    logic [N_IN-1:0] stim;
    logic            busy;
    logic            done;

    tt_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != APPLY),
        .enable (state == APPLY),
        .expire (expire)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = APPLY;
            APPLY:   if (expire)    state_nxt = SAMPLE;
            SAMPLE:  state_nxt = (row == ROW_LAST) ? DONE : APPLY;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        stim = '0;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            APPLY, SAMPLE: begin
                stim = row;
                busy = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Shadow with the current row's sample merged in.
    always_comb begin
        shadow_nxt = shadow;
        for (int i = 0; i < TW; i++) begin
            if (i == row_bit(TW, int'(row))) shadow_nxt[i] = bus.dut_out;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row <= '0;
        end else if (state == IDLE) begin
            row <= '0;
        end else if (state == SAMPLE && row != ROW_LAST) begin
            row <= row + 1'b1;
        end
    end

    // Results load on the edge that enters DONE, so they are already valid while
    // done is high and include the final row's sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow        <= '0;
            table_code    <= '0;
            match         <= 1'b0;
            mismatch_mask <= '0;
        end else if (state == SAMPLE) begin
            shadow <= shadow_nxt;
            if (row == ROW_LAST) begin
                table_code    <= shadow_nxt;
                match         <= (shadow_nxt == EXPECTED);
                mismatch_mask <= shadow_nxt ^ EXPECTED;
            end
        end
    end

    assign bus.stim          = stim;
    assign bus.busy          = busy;
    assign bus.done          = done;
    assign bus.table_code    = table_code;
    assign bus.match         = match;
    assign bus.mismatch_mask = mismatch_mask;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (settle 4 and settle 1) against gate models.
// Latency: expected done cycle is carried in each scoreboard entry.
// Backpressure: n/a.
module tb_truth_table_sweeper;
    import tt_sweep_pkg::*;

    localparam logic [7:0] GATE_CODE = 8'hF4;
    localparam logic [7:0] EXP_CODE  = 8'hF4;
    localparam int         TW        = 8;

    typedef struct {
        logic [7:0] code;
        logic [7:0] mask;
        logic       match;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   mode_a = 0;
    int   mode_b = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [2:0] da1 = '0, da2 = '0, da3 = '0;
    logic [2:0] db1 = '0, db2 = '0, db3 = '0;
    logic pa = 1'b0, pb = 1'b0;

    truth_table_sweeper_if #(.N_IN(3)) ia ();
    truth_table_sweeper_if #(.N_IN(3)) ib ();

    truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(4), .EXPECTED(EXP_CODE)) dut_a (
        .clk (clk), .reset (reset), .bus (ia.master));
    truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(1), .EXPECTED(EXP_CODE)) dut_b (
        .clk (clk), .reset (reset), .bus (ib.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate models: 0 = 0xF4 gate, 1 = tied low, 2 = 0xF4 gate seen through a 3-cycle delay.
    function automatic logic gate_fn(input int x);
        logic [7:0] g;
        g = GATE_CODE;
        return g[3'(7 - x)];
    endfunction

    function automatic logic gate_out(input int mode, input logic [2:0] s, input logic [2:0] d);
        case (mode)
            0:       return gate_fn(int'(s));
            2:       return gate_fn(int'(d));
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        da1 <= ia.stim; da2 <= da1; da3 <= da2;
        db1 <= ib.stim; db2 <= db1; db3 <= db2;
    end

    assign ia.dut_out = gate_out(mode_a, ia.stim, da3);
    assign ib.dut_out = gate_out(mode_b, ib.stim, db3);

    // Expected code from the sweep timeline: row r is driven in the S+1 intervals
    // following edges r*(S+1).., sampled in the last one; the delayed gate sees the
    // stimulus of three intervals earlier (0 before the sweep began).
    function automatic logic [7:0] model_code(input int mode, input int settle);
        logic [7:0] c;
        int j, src, srow;
        c = '0;
        for (int r = 0; r < TW; r++) begin
            j = r * (settle + 1) + settle;
            case (mode)
                0: c[7 - r] = gate_fn(r);
                2: begin
                    src  = j - 3;
                    srow = (src < 0) ? 0 : src / (settle + 1);
                    c[7 - r] = gate_fn(srow);
                end
                default: c[7 - r] = 1'b0;
            endcase
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic score(input string tag, input exp_t e, input logic [7:0] code, input logic m,
                         input logic [7:0] mask, input logic [2:0] stim, input logic busy);
        check({tag, "_code"},  32'(code), 32'(e.code));
        check({tag, "_match"}, 32'(m),    32'(e.match));
        check({tag, "_mask"},  32'(mask), 32'(e.mask));
        check({tag, "_cycle"}, 32'(cyc),  32'(e.due));
        check({tag, "_stim"},  32'(stim), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd1);
    endtask

    // Monitors: pop on every done pulse; also check the cycle after done is idle with stim 0.
    always @(negedge clk) begin
        if (pa) begin
            check("a_post_done_stim", 32'(ia.stim), 32'd0);
            check("a_post_done_busy", 32'(ia.busy), 32'd0);
        end
        if (ia.done) begin
            check("a_done_expected", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) score("a", qa.pop_front(), ia.table_code, ia.match,
                                      ia.mismatch_mask, ia.stim, ia.busy);
        end
        pa <= ia.done;
    end

    always @(negedge clk) begin
        if (pb) begin
            check("b_post_done_stim", 32'(ib.stim), 32'd0);
            check("b_post_done_busy", 32'(ib.busy), 32'd0);
        end
        if (ib.done) begin
            check("b_done_expected", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) score("b", qb.pop_front(), ib.table_code, ib.match,
                                      ib.mismatch_mask, ib.stim, ib.busy);
        end
        pb <= ib.done;
    end

    // Called at a negedge. Holds start for 'hold' edges; pushes one expectation per sweep
    // the held start will launch (a new sweep every TW*(S+1)+2 edges).
    task automatic start_sweep(input bit sel_b, input int hold, input int settle,
                               input int mode, input bit push);
        exp_t e;
        int   c;
        c = cyc;
        e.code  = model_code(mode, settle);
        e.match = (e.code == EXP_CODE);
        e.mask  = e.code ^ EXP_CODE;
        if (push) begin
            for (int k = 0; k < hold; k += TW * (settle + 1) + 2) begin
                e.due = c + k + TW * (settle + 1) + 1;
                if (sel_b) qb.push_back(e);
                else       qa.push_back(e);
            end
        end
        if (sel_b) ib.start = 1'b1;
        else       ia.start = 1'b1;
        repeat (hold) @(negedge clk);
        ia.start = 1'b0;
        ib.start = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int max_cycles);
        int n = 0;
        while ((qa.size() + qb.size()) != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, 32'(qa.size() + qb.size()), 32'd0);
        repeat (6) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(ia.busy),          32'd0);
        check({tag, "_done"},  32'(ia.done),          32'd0);
        check({tag, "_stim"},  32'(ia.stim),          32'd0);
        check({tag, "_code"},  32'(ia.table_code),    32'd0);
        check({tag, "_match"}, 32'(ia.match),         32'd0);
        check({tag, "_mask"},  32'(ia.mismatch_mask), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        ia.start = 1'b0;
        ib.start = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 0xF4 gate, single start pulse
        mode_a = 0;
        start_sweep(1'b0, 1, 4, 0, 1'b1);
        wait_drain("t1", 80);

        // Reset at cycle ~20 of a sweep: everything clears, no done
        start_sweep(1'b0, 1, 4, 0, 1'b0);
        repeat (18) @(negedge clk);
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        start_sweep(1'b0, 1, 4, 0, 1'b1);
        wait_drain("t3", 80);

        // Gate tied low
        mode_a = 1;
        start_sweep(1'b0, 1, 4, 1, 1'b1);
        wait_drain("t2", 80);

        // Stray start during a sweep is ignored
        mode_a = 0;
        start_sweep(1'b0, 1, 4, 0, 1'b1);
        repeat (8) @(negedge clk);
        ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0;
        wait_drain("t4", 80);
        repeat (40) @(negedge clk);

        // Start held for 100 cycles: back-to-back sweeps
        start_sweep(1'b0, 100, 4, 0, 1'b1);
        wait_drain("t5", 200);

        // Delayed gate: settle 4 absorbs the delay, settle 1 does not
        mode_a = 2;
        start_sweep(1'b0, 1, 4, 2, 1'b1);
        wait_drain("t6a", 80);
        mode_b = 2;
        start_sweep(1'b1, 1, 1, 2, 1'b1);
        wait_drain("t6b", 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

endmodule
